// File: rtl/lc3b_mar_mux.sv
// LC-3b Memory Address Register with a 2:1 source select.
// The MAR loads either the address-adder result or the word-aligned,
// zero-extended trap vector taken from IR[7:0]. It holds between loads and
// clears asynchronously on an active-low reset.
module lc3b_mar_mux #(
  parameter int unsigned WIDTH = 16,
  parameter logic        ADDER = 1'b0,
  parameter logic        IR    = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             LD_MAR,
  input  logic             MAR_SEL,
  input  logic [WIDTH-1:0] ir,
  input  logic [WIDTH-1:0] adder,
  output logic [WIDTH-1:0] MAR
);

  // The power-up value matches the reset value, so MAR reads zero before the
  // first load even if reset is never asserted.
  logic [WIDTH-1:0] mar_q = '0;
  logic [WIDTH-1:0] mar_d;
  logic [WIDTH-1:0] trapvect;

  // Only the trap vector byte of IR is used. The upper byte is intentionally ignored.
  logic unused_ir_hi;
  assign unused_ir_hi = ^ir[WIDTH-1:8];

  // ZEXT(trapvect8) << 1. Bit 7 lands in bit 8, and bit 0 is always zero.
  assign trapvect = {{(WIDTH-9){1'b0}}, ir[7:0], 1'b0};

  // Select the next MAR value. If MAR_SEL is not a clean IR code (including X),
  // the adder source is used.
  always_comb begin
    mar_d = mar_q;
    if (LD_MAR) begin
      if (MAR_SEL == IR) mar_d = trapvect;
      else               mar_d = adder;
    end
  end

  // Register with asynchronous active-low clear. Reset has priority over loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mar_q <= '0;
    else          mar_q <= mar_d;
  end

  assign MAR = mar_q;

endmodule

// File: tb/tb_lc3b_mar_mux.sv
// Directed, table-driven bench for lc3b_mar_mux, plus hand-written sequences
// for hold behaviour, asynchronous reset and back-to-back loads.
module tb_lc3b_mar_mux;

  logic        clk;
  logic        reset_n;
  logic        LD_MAR;
  logic        MAR_SEL;
  logic [15:0] ir;
  logic [15:0] adder;
  logic [15:0] MAR;

  int unsigned n_tests;
  int unsigned n_fail;

  typedef struct {
    logic        ld;
    logic        sel;
    logic [15:0] ir;
    logic [15:0] adder;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  lc3b_mar_mux #(.WIDTH(16), .ADDER(1'b0), .IR(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .LD_MAR  (LD_MAR),
    .MAR_SEL (MAR_SEL),
    .ir      (ir),
    .adder   (adder),
    .MAR     (MAR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] exp);
    n_tests++;
    if (MAR !== exp) begin
      n_fail++;
      $display("FAIL %s: MAR got %h expected %h", name, MAR, exp);
    end
  endtask

  // Drive inputs away from the rising edge, then sample 1 time unit after it.
  task automatic step(input logic ld, input logic sel,
                      input logic [15:0] i_ir, input logic [15:0] i_add);
    @(negedge clk);
    LD_MAR  = ld;
    MAR_SEL = sel;
    ir      = i_ir;
    adder   = i_add;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b1;
    LD_MAR  = 1'b0;
    MAR_SEL = 1'b0;
    ir      = 16'h0000;
    adder   = 16'h0000;

    //            ld    sel   ir        adder     expected
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0005, 16'h0005};
    vecs[1]  = '{1'b1, 1'b1, 16'h0002, 16'h7777, 16'h0004};
    vecs[2]  = '{1'b1, 1'b1, 16'h1111, 16'h7777, 16'h0022};
    vecs[3]  = '{1'b1, 1'b1, 16'h1181, 16'h7777, 16'h0102};
    vecs[4]  = '{1'b0, 1'b0, 16'hFFFF, 16'h1234, 16'h0102};
    vecs[5]  = '{1'b0, 1'b1, 16'h00FF, 16'hAAAA, 16'h0102};
    vecs[6]  = '{1'b1, 1'b0, 16'h00FF, 16'hFFFF, 16'hFFFF};
    vecs[7]  = '{1'b1, 1'b1, 16'h00FF, 16'h0000, 16'h01FE};
    vecs[8]  = '{1'b1, 1'b1, 16'hFF80, 16'h0000, 16'h0100};
    vecs[9]  = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, 16'h00FF, 16'h8001, 16'h8001};
    vecs[11] = '{1'b1, 1'b1, 16'hAB7F, 16'h8001, 16'h00FE};

    // Power-up value before any reset or load
    #1;
    check("powerup", 16'h0000);

    // Reset pulse with no loads
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("reset_low", 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", 16'h0000);

    for (int unsigned i = 0; i < 12; i++) begin
      step(vecs[i].ld, vecs[i].sel, vecs[i].ir, vecs[i].adder);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Put 16'h0102 in MAR, then hold it for several edges while the inputs change.
    step(1'b1, 1'b1, 16'h1181, 16'h0000);
    check("load_0102", 16'h0102);
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b0, i[0], 16'h5A5A ^ 16'(i), 16'hC3C3 + 16'(i));
      check($sformatf("hold%0d", i), 16'h0102);
    end

    // With LD_MAR low, an input change between edges must not reach MAR.
    #2;
    adder   = 16'hDEAD;
    MAR_SEL = 1'b0;
    #1;
    check("no_comb_path", 16'h0102);

    // Drop reset between edges. MAR must clear at once.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 16'h0000);
    // A load request while reset is low must be ignored.
    LD_MAR  = 1'b1;
    MAR_SEL = 1'b0;
    adder   = 16'h4444;
    @(posedge clk);
    #1;
    check("reset_dominates", 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    LD_MAR  = 1'b0;
    step(1'b1, 1'b0, 16'h0000, 16'hBEEF);
    check("load_after_reset", 16'hBEEF);

    // Holding LD_MAR high must reload MAR on every edge.
    step(1'b1, 1'b0, 16'h0000, 16'h0001);
    check("b2b0", 16'h0001);
    step(1'b1, 1'b1, 16'h0040, 16'h0002);
    check("b2b1", 16'h0080);
    step(1'b1, 1'b0, 16'h0040, 16'h0003);
    check("b2b2", 16'h0003);
    step(1'b0, 1'b1, 16'h0041, 16'h0004);
    check("b2b_hold", 16'h0003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3b_mar_mux.md
Name: lc3b_mar_mux

Overview:
- Memory Address Register (MAR) with a 2:1 input select for the LC-3b datapath.
- Loads either the address-adder output or the zero-extended, word-aligned trap vector taken from IR[7:0].
- Output feeds the memory address bus and holds between loads.

Parameters:
- WIDTH, 16, datapath and MAR width; ir and adder share it; only 16 is required to work.
- ADDER, 1'b0, MAR_SEL encoding that selects the adder input. Named constant, hierarchically visible as instance.ADDER.
- IR, 1'b1, MAR_SEL encoding that selects the IR trap-vector input. Named constant, hierarchically visible as instance.IR.

Ports:
- clk  input  1  system clock; all loads on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- LD_MAR  input  1  load enable; MAR captures the selected source on a rising clk while high.
- MAR_SEL  input  1  source select: ADDER (0) or IR (1).
- ir  input  16  instruction register contents; only bits [7:0] are used.
- adder  input  16  address-adder result.
- MAR  output  16  registered memory address.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: reset_n low forces MAR = 16'h0000 immediately, without waiting for clk. MAR stays 0 while reset_n is low. Reset dominates LD_MAR.
- MAR also powers up / initialises to 16'h0000, so it reads 0 before the first load even if reset is never asserted.
- Load: at a rising clk with reset_n high and LD_MAR = 1:
  - MAR_SEL = ADDER: MAR <= adder[15:0], passed through unmodified.
  - MAR_SEL = IR: MAR <= {7'b0, ir[7:0], 1'b0}, i.e. ZEXT(trapvect8) << 1.
    - ir[15:8] is ignored.
    - Bit 7 of ir lands in MAR[8]; it is zero-extended, never sign-extended.
    - MAR[0] is always 0 for this source.
- Hold: LD_MAR = 0 at a rising clk leaves MAR unchanged, regardless of MAR_SEL, ir or adder.
- Latency: one clock. The new value is visible after the loading edge and stays stable until the next load or reset.
- Input changes with LD_MAR = 0 have no effect. There is no combinational path from inputs to MAR.
- MAR_SEL is sampled only at the loading edge; it may change freely at other times.
- Unknown (X) MAR_SEL during a load: treat as ADDER.
- Reset asserted mid-sequence: MAR clears asynchronously. The first rising clk after release with LD_MAR = 1 loads normally.
- Reset released coincident with a rising clk edge: that edge is ignored; MAR remains 0.
- No handshake or ready signal; LD_MAR may be held high for consecutive cycles, and each edge reloads.

Test Plan:
- Power-up / reset: pulse reset_n low, no loads -> MAR = 16'h0000.
- Adder load: adder = 16'h0005, MAR_SEL = ADDER, LD_MAR high for one rising edge -> MAR = 16'h0005.
- IR load, small vector: ir = 16'h0002, MAR_SEL = IR, load -> MAR = 16'h0004.
- IR load, high byte discarded: ir = 16'h1111 -> MAR = 16'h0022. Then ir = 16'h1181 -> MAR = 16'h0102 (bit 7 shifted into bit 8, no sign extension).
- Hold and full-width pass-through:
  - After a load, set LD_MAR = 0, change adder and ir, run several edges -> MAR unchanged.
  - adder = 16'hFFFF with MAR_SEL = ADDER -> MAR = 16'hFFFF.
- Async reset mid-operation: with MAR = 16'h0102, drop reset_n between clock edges -> MAR = 0 immediately. Release, then load ADDER with 16'hBEEF -> MAR = 16'hBEEF.
